float_normalizer: RTL

- Multi-cycle post-arithmetic normalizer that sits directly upstream of float_rounder.
- Accepts an unnormalized significand (carry bit + N result bits + guard + sticky) with a biased exponent.
- Shifts the significand to the normal position, or clamps it at the subnormal boundary.
- Delivers sign, N-bit mantissa A, 2-bit {guard, sticky} and the adjusted exponent, ready for rounding; round mode travels with the payload.

---
 rtl/float_normalizer_pkg.sv | 25 ++
 rtl/float_norm_step.sv | 68 ++++++
 rtl/float_normalizer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/float_normalizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_normalizer_pkg
// Description : Shared FPU definitions: rounding-mode encoding used by the
//               rounder and normalizer, and the normalizer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package float_normalizer_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,   // round to nearest, ties to even
        RTZ = 3'd1,   // round toward zero
        RDN = 3'd2,   // round toward -inf
        RUP = 3'd3,   // round toward +inf
        RMM = 3'd4    // round to nearest, ties away
    } round_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage : float_normalizer_pkg
`default_nettype wire

// File: rtl/float_norm_step.sv
`default_nettype none
// ============================================================================
// Module      : float_norm_step
// Description : One normalization step (combinational). Decides the single
//               action for this cycle in priority order: zero, right shift on
//               carry, already normal, subnormal clamp, or left shift.
// Ports       : i_sig/i_exp   current significand and exponent
//               o_sig/o_exp   updated significand and exponent
//               o_done        action finishes normalization
//               o_zero/o_sub/o_ovf  result flags raised by this step
// Revision    : 1.0 - initial release
// ============================================================================
module float_norm_step #(
    parameter int N = 4,
    parameter int E = 8
) (
    input  logic [N+2:0] i_sig,
    input  logic [E-1:0] i_exp,
    output logic [N+2:0] o_sig,
    output logic [E-1:0] o_exp,
    output logic         o_done,
    output logic         o_zero,
    output logic         o_sub,
    output logic         o_ovf
);
    localparam int W = N + 3;
    localparam logic [E-1:0] c_ONE = {{(E-1){1'b0}}, 1'b1};

    logic [E-1:0] w_exp_inc;
    logic [E-1:0] w_exp_dec;

    assign w_exp_inc = i_exp + c_ONE;
    assign w_exp_dec = i_exp - c_ONE;

    always_comb begin
        o_sig  = i_sig;
        o_exp  = i_exp;
        o_done = 1'b0;
        o_zero = 1'b0;
        o_sub  = 1'b0;
        o_ovf  = 1'b0;
        if (i_sig == '0) begin
            o_zero = 1'b1;
            o_exp  = '0;
            o_done = 1'b1;
        end else if (i_sig[W-1]) begin
            // Carry out: shift right, folding the old guard into sticky so
            // no discarded nonzero bit is lost for rounding.
            o_sig  = {1'b0, i_sig[W-1:2], i_sig[1] | i_sig[0]};
            o_exp  = w_exp_inc;
            o_ovf  = (w_exp_inc == '1);
            o_done = 1'b1;
        end else if (i_sig[W-2]) begin
            o_done = 1'b1;
        end else if (i_exp <= c_ONE) begin
            // Cannot shift further left without going below the minimum
            // exponent: leave the significand denormal.
            o_sub  = 1'b1;
            o_exp  = '0;
            o_done = 1'b1;
        end else begin
            o_sig = {i_sig[W-2:0], 1'b0};
            o_exp = w_exp_dec;
        end
    end

endmodule : float_norm_step
`default_nettype wire

// File: rtl/float_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : float_normalizer
// Description : Multi-cycle post-arithmetic normalizer feeding the rounder.
//               Accepts an unnormalized significand with carry/guard/sticky,
//               shifts it one bit per cycle to the normal position (or clamps
//               at the subnormal boundary) and presents the result with a
//               valid/ready handshake. One operation in flight at a time.
// Ports       : clock, reset            clock, synchronous active-high reset
//               in_valid/in_ready       input handshake
//               sign_in, exp_in, sig_in, round_mode_in   input payload
//               out_valid/out_ready     output handshake
//               sign, A, sticky, exp_out, round_mode     output payload
//               subnormal, zero, overflow                result flags
// Revision    : 1.0 - initial release
// ============================================================================
module float_normalizer
    import float_normalizer_pkg::*;
#(
    parameter int N = 4,
    parameter int E = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sign_in,
    input  logic [E-1:0] exp_in,
    input  logic [N+2:0] sig_in,
    input  round_mode_t  round_mode_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sign,
    output logic [N-1:0] A,
    output logic [1:0]   sticky,
    output logic [E-1:0] exp_out,
    output round_mode_t  round_mode,
    output logic         subnormal,
    output logic         zero,
    output logic         overflow
);
    localparam int W = N + 3;
    localparam logic [E-1:0] c_ONE = {{(E-1){1'b0}}, 1'b1};

    norm_state_t  r_state;
    norm_state_t  w_state_nxt;

    logic [W-1:0] r_sig;
    logic [E-1:0] r_exp;
    logic         r_sign;
    round_mode_t  r_rm;
    logic         r_sub;
    logic         r_zero;
    logic         r_ovf;

    logic [W-1:0] w_sig;
    logic [E-1:0] w_exp;
    logic         w_done;
    logic         w_zero;
    logic         w_sub;
    logic         w_ovf;

    float_norm_step #(
        .N (N),
        .E (E)
    ) u_step (
        .i_sig  (r_sig),
        .i_exp  (r_exp),
        .o_sig  (w_sig),
        .o_exp  (w_exp),
        .o_done (w_done),
        .o_zero (w_zero),
        .o_sub  (w_sub),
        .o_ovf  (w_ovf)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Payload registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sig  <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_rm   <= RNE;
            r_sub  <= 1'b0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sig  <= sig_in;
                        // Exponent 0 encodes subnormals, whose scale is that
                        // of exponent 1.
                        r_exp  <= (exp_in == '0) ? c_ONE : exp_in;
                        r_sign <= sign_in;
                        r_rm   <= round_mode_in;
                        r_sub  <= 1'b0;
                        r_zero <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_sig  <= w_sig;
                    r_exp  <= w_exp;
                    r_sub  <= w_sub;
                    r_zero <= w_zero;
                    r_ovf  <= w_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign sign       = r_sign;
    assign A          = r_sig[W-2:2];
    assign sticky     = r_sig[1:0];
    assign exp_out    = r_exp;
    assign round_mode = r_rm;
    assign subnormal  = r_sub;
    assign zero       = r_zero;
    assign overflow   = r_ovf;

endmodule : float_normalizer
`default_nettype wire
